// File: rtl/rom_read_arbiter_if.sv
// Bundle between the ROM read arbiter, its two burst requesters and the shared ROM.
// The slave modport is the arbiter's view; master is the client/ROM side.
interface rom_read_arbiter_if #(
   parameter int unsigned ADDR_W = 9,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned LEN_W  = 4
);
   logic              req0;
   logic [ADDR_W-1:0] addr0;
   logic [LEN_W-1:0]  len0;
   logic              gnt0;
   logic              req1;
   logic [ADDR_W-1:0] addr1;
   logic [LEN_W-1:0]  len1;
   logic              gnt1;
   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_data;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              rd_last;
   logic              rd_id;
   logic              busy;

   modport slave (
      input  req0, addr0, len0, req1, addr1, len1, rom_data,
      output gnt0, gnt1, rom_addr, rd_data, rd_valid, rd_last, rd_id, busy
   );

   modport master (
      output req0, addr0, len0, req1, addr1, len1, rom_data,
      input  gnt0, gnt1, rom_addr, rd_data, rd_valid, rd_last, rd_id, busy
   );
endinterface

// File: rtl/rom_read_arbiter.sv
// Round-robin arbiter sharing one combinational-read ROM between two burst readers;
// sequences the burst address and returns a registered, ID-tagged data stream.
module rom_read_arbiter #(
   parameter int unsigned ADDR_W = 9,
   parameter int unsigned DATA_W = 8,
   parameter int unsigned LEN_W  = 4
) (
   input  logic               clk,
   input  logic               rst,
   rom_read_arbiter_if.slave  bus
);
   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_BURST = 1'b1;

   logic [0:0]        state_q, state_d;
   logic              last_id_q, last_id_d;
   logic              tag_q, tag_d;
   logic [LEN_W-1:0]  count_q, count_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              valid_q, valid_d;
   logic              last_q, last_d;
   logic              id_q, id_d;
   logic              busy_q, busy_d;
   logic              gnt0_q, gnt0_d;
   logic              gnt1_q, gnt1_d;
   logic              pick0_c, pick1_c;

   // On a tie the requester that was not served last wins.
   assign pick0_c = bus.req0 && (!bus.req1 || last_id_q);
   assign pick1_c = bus.req1 && (!bus.req0 || !last_id_q);

   always_comb begin
      state_d   = state_q;
      last_id_d = last_id_q;
      tag_d     = tag_q;
      count_d   = count_q;
      addr_d    = addr_q;
      data_d    = data_q;
      valid_d   = 1'b0;
      last_d    = 1'b0;
      id_d      = id_q;
      busy_d    = busy_q;
      gnt0_d    = 1'b0;
      gnt1_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pick0_c) begin
               gnt0_d    = 1'b1;
               addr_d    = bus.addr0;
               count_d   = bus.len0;
               tag_d     = 1'b0;
               last_id_d = 1'b0;
               busy_d    = 1'b1;
               state_d   = ST_BURST;
            end else if (pick1_c) begin
               gnt1_d    = 1'b1;
               addr_d    = bus.addr1;
               count_d   = bus.len1;
               tag_d     = 1'b1;
               last_id_d = 1'b1;
               busy_d    = 1'b1;
               state_d   = ST_BURST;
            end
         end
         ST_BURST: begin
            data_d  = bus.rom_data;
            valid_d = 1'b1;
            id_d    = tag_q;
            last_d  = (count_q == LEN_W'(0));
            if (count_q != LEN_W'(0)) begin
               addr_d  = addr_q + ADDR_W'(1);
               count_d = count_q - LEN_W'(1);
            end else begin
               busy_d  = 1'b0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            busy_d  = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         last_id_q <= 1'b1;
         tag_q     <= 1'b0;
         count_q   <= '0;
         addr_q    <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         last_q    <= 1'b0;
         id_q      <= 1'b0;
         busy_q    <= 1'b0;
         gnt0_q    <= 1'b0;
         gnt1_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         last_id_q <= last_id_d;
         tag_q     <= tag_d;
         count_q   <= count_d;
         addr_q    <= addr_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         last_q    <= last_d;
         id_q      <= id_d;
         busy_q    <= busy_d;
         gnt0_q    <= gnt0_d;
         gnt1_q    <= gnt1_d;
      end
   end

   assign bus.gnt0     = gnt0_q;
   assign bus.gnt1     = gnt1_q;
   assign bus.rom_addr = addr_q;
   assign bus.rd_data  = data_q;
   assign bus.rd_valid = valid_q;
   assign bus.rd_last  = last_q;
   assign bus.rd_id    = id_q;
   assign bus.busy     = busy_q;
endmodule

// File: tb/tb_rom_read_arbiter.sv
// Directed bench for rom_read_arbiter with a ROM model returning addr[7:0] ^ 8'hA5.
module tb_rom_read_arbiter;
   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   rom_read_arbiter_if #(.ADDR_W(9), .DATA_W(8), .LEN_W(4)) bus ();

   rom_read_arbiter #(.ADDR_W(9), .DATA_W(8), .LEN_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   assign bus.rom_data = bus.rom_addr[7:0] ^ 8'hA5;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Waits up to budget negedges for the grant of requester id, then checks the grant cycle.
   task automatic wait_gnt(input logic id, input logic [8:0] start, input int budget);
      logic found;
      found = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if ((id ? bus.gnt1 : bus.gnt0) === 1'b1) begin
            found = 1'b1;
            break;
         end
      end
      check("gnt_seen", 32'(found), 32'd1);
      if (found) begin
         check("gnt_other", 32'(id ? bus.gnt0 : bus.gnt1), 32'd0);
         check("gnt_busy", 32'(bus.busy), 32'd1);
         check("gnt_valid", 32'(bus.rd_valid), 32'd0);
         check("gnt_addr", 32'(bus.rom_addr), 32'(start));
      end
   endtask

   // Checks the n beats that follow a grant cycle.
   task automatic check_burst(input logic id, input logic [8:0] start, input int n);
      logic [8:0] a;
      logic [8:0] a_next;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         a      = 9'(start + 9'(k));
         a_next = (k < n - 1) ? 9'(a + 9'd1) : a;
         check("beat_valid", 32'(bus.rd_valid), 32'd1);
         check("beat_data", 32'(bus.rd_data), 32'(a[7:0] ^ 8'hA5));
         check("beat_last", 32'(bus.rd_last), 32'(k == n - 1));
         check("beat_id", 32'(bus.rd_id), 32'(id));
         check("beat_gnt", 32'({bus.gnt1, bus.gnt0}), 32'd0);
         check("beat_busy", 32'(bus.busy), 32'(k != n - 1));
         check("beat_addr", 32'(bus.rom_addr), 32'(a_next));
      end
   endtask

   task automatic check_idle();
      @(negedge clk);
      check("idle_valid", 32'(bus.rd_valid), 32'd0);
      check("idle_last", 32'(bus.rd_last), 32'd0);
      check("idle_busy", 32'(bus.busy), 32'd0);
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b0;
      bus.req0 = 1'b0; bus.addr0 = '0; bus.len0 = '0;
      bus.req1 = 1'b0; bus.addr1 = '0; bus.len1 = '0;
      repeat (2) @(negedge clk);
      check("rst_gnt", 32'({bus.gnt1, bus.gnt0}), 32'd0);
      check("rst_valid", 32'(bus.rd_valid), 32'd0);
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_addr", 32'(bus.rom_addr), 32'd0);
      check("rst_data", 32'(bus.rd_data), 32'd0);
      rst = 1'b1;

      // Single burst: 0x010..0x013 -> B5 B4 B7 B6.
      bus.req0 = 1'b1; bus.addr0 = 9'h010; bus.len0 = 4'd3;
      wait_gnt(1'b0, 9'h010, 4);
      bus.req0 = 1'b0;
      check_burst(1'b0, 9'h010, 4);
      check("t1_beat0_const", 32'(9'h010 ^ 9'h0A5), 32'h0B5);
      check_idle();

      // Both requesting from reset, len 0: alternate 0,1,0,1 every two cycles.
      rst = 1'b0;
      bus.req0 = 1'b1; bus.addr0 = 9'h0AA; bus.len0 = 4'd0;
      bus.req1 = 1'b1; bus.addr1 = 9'h155; bus.len1 = 4'd0;
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (i % 2 == 0) begin
            check("rr_gnt0", 32'(bus.gnt0), 32'(i % 4 == 0));
            check("rr_gnt1", 32'(bus.gnt1), 32'(i % 4 == 2));
            check("rr_idle_valid", 32'(bus.rd_valid), 32'd0);
         end else begin
            check("rr_valid", 32'(bus.rd_valid), 32'd1);
            check("rr_last", 32'(bus.rd_last), 32'd1);
            check("rr_id", 32'(bus.rd_id), 32'(i % 4 == 3));
            check("rr_data", 32'(bus.rd_data), (i % 4 == 3) ? 32'hF0 : 32'h0F);
            check("rr_gnt", 32'({bus.gnt1, bus.gnt0}), 32'd0);
         end
      end
      bus.req0 = 1'b0; bus.req1 = 1'b0;
      check_idle();

      // Wrap: 0x1FE,0x1FF,0x000,0x001 -> 5B 5A A5 A4.
      bus.req1 = 1'b1; bus.addr1 = 9'h1FE; bus.len1 = 4'd3;
      wait_gnt(1'b1, 9'h1FE, 4);
      bus.req1 = 1'b0;
      check_burst(1'b1, 9'h1FE, 4);
      check_idle();

      // Max burst with req1 raised mid-burst; req1 must be granted right after beat 16's idle cycle.
      bus.req0 = 1'b1; bus.addr0 = 9'h100; bus.len0 = 4'd15;
      wait_gnt(1'b0, 9'h100, 4);
      bus.req0 = 1'b0;
      bus.req1 = 1'b1; bus.addr1 = 9'h033; bus.len1 = 4'd0;
      check_burst(1'b0, 9'h100, 16);
      wait_gnt(1'b1, 9'h033, 1);
      bus.req1 = 1'b0;
      check_burst(1'b1, 9'h033, 1);
      check_idle();

      // Asynchronous reset during beat 2 of an 8-beat burst.
      bus.req0 = 1'b1; bus.addr0 = 9'h040; bus.len0 = 4'd7;
      wait_gnt(1'b0, 9'h040, 4);
      bus.req0 = 1'b0;
      repeat (3) @(negedge clk);
      check("ar_pre_valid", 32'(bus.rd_valid), 32'd1);
      check("ar_pre_data", 32'(bus.rd_data), 32'(8'h42 ^ 8'hA5));
      #2 rst = 1'b0;
      #1;
      check("ar_valid", 32'(bus.rd_valid), 32'd0);
      check("ar_last", 32'(bus.rd_last), 32'd0);
      check("ar_id", 32'(bus.rd_id), 32'd0);
      check("ar_data", 32'(bus.rd_data), 32'd0);
      check("ar_busy", 32'(bus.busy), 32'd0);
      check("ar_gnt", 32'({bus.gnt1, bus.gnt0}), 32'd0);
      check("ar_addr", 32'(bus.rom_addr), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      repeat (4) check_idle();

      // req0 held with len 1: served every 3 cycles, gnt1 never seen.
      bus.req0 = 1'b1; bus.addr0 = 9'h020; bus.len0 = 4'd1;
      wait_gnt(1'b0, 9'h020, 4);
      for (int r = 0; r < 3; r++) begin
         check_burst(1'b0, 9'h020, 2);
         if (r < 2) wait_gnt(1'b0, 9'h020, 1);
      end
      bus.req0 = 1'b0;
      check_idle();
      check_idle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
